// File: rtl/sseg_scan_driver_if.sv
// Display bundle between status logic (master) and the seven-segment scan driver (slave).
// The brightness signal exists only when SSEG_PWM_DIM_EN is defined.
interface sseg_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   enable;
    logic [NUM_DIGITS-1:0]   dp;
`ifdef SSEG_PWM_DIM_EN
    logic [3:0]              brightness;
`endif
    logic [7:0]              SSEG_CA;
    logic [NUM_DIGITS-1:0]   SSEG_AN;
    logic [IDX_W-1:0]        digit_idx;
    logic                    frame_tick;

    modport master (
`ifdef SSEG_PWM_DIM_EN
        output brightness,
`endif
        output value, enable, dp,
        input  SSEG_CA, SSEG_AN, digit_idx, frame_tick
    );

    modport slave (
`ifdef SSEG_PWM_DIM_EN
        input  brightness,
`endif
        input  value, enable, dp,
        output SSEG_CA, SSEG_AN, digit_idx, frame_tick
    );
endinterface

// File: rtl/sseg_scan_driver.sv
// Multiplexed common-anode seven-segment scanner with per-slot blank window and per-frame input snapshot.
// Optional PWM dimming is enabled by defining SSEG_PWM_DIM_EN.
module sseg_scan_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int DIV_CYCLES   = 20000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    sseg_scan_driver_if.slave bus
);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int TIMER_W = $clog2(DIV_CYCLES);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_digits
        $error("sseg_scan_driver: NUM_DIGITS must be 1..16");
    end
    if (DIV_CYCLES < 2) begin : g_bad_div
        $error("sseg_scan_driver: DIV_CYCLES must be >= 2");
    end
    if (BLANK_CYCLES < 0 || BLANK_CYCLES >= DIV_CYCLES) begin : g_bad_blank
        $error("sseg_scan_driver: BLANK_CYCLES must be 0..DIV_CYCLES-1");
    end

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h27;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    logic [TIMER_W-1:0]      timer_q, timer_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] value_s_q;
    logic [NUM_DIGITS-1:0]   enable_s_q, dp_s_q;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [7:0]              ca_q, ca_d;
    logic [IDX_W-1:0]        digit_idx_q;
    logic                    frame_tick_q;
    logic                    timer_wrap, idx_last, snap, show, gate;

`ifdef SSEG_PWM_DIM_EN
    logic [3:0] pwm_q, brightness_s_q;

    always_ff @(posedge clk) begin
        if (!reset_n) pwm_q <= 4'd0;
        else          pwm_q <= pwm_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n || snap) brightness_s_q <= bus.brightness;
    end

    assign gate = (pwm_q <= brightness_s_q);
`else
    assign gate = 1'b1;
`endif

    assign timer_wrap = (timer_q == TIMER_W'(DIV_CYCLES - 1));
    assign idx_last   = (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign snap       = timer_wrap && idx_last;
    assign show       = (int'(timer_q) >= BLANK_CYCLES);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        timer_d = timer_q + TIMER_W'(1);
        idx_d   = idx_q;
        an_d    = '1;
        ca_d    = 8'hFF;
        if (timer_wrap) begin
            timer_d = '0;
            idx_d   = idx_last ? '0 : idx_q + IDX_W'(1);
        end
        // Cathodes carry the code even when PWM gates the anode off.
        if (show && enable_s_q[idx_q]) begin
            ca_d = {~dp_s_q[idx_q], hex7(value_s_q[{idx_q, 2'b00} +: 4])};
            if (gate) an_d[idx_q] = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timer_q      <= '0;
            idx_q        <= '0;
            an_q         <= '1;
            ca_q         <= 8'hFF;
            digit_idx_q  <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            timer_q      <= timer_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            ca_q         <= ca_d;
            digit_idx_q  <= idx_q;
            frame_tick_q <= snap;
        end
    end

    // NOTE: the shadows have no reset value; they track the inputs during reset instead.
    always_ff @(posedge clk) begin
        if (!reset_n || snap) begin
            value_s_q  <= bus.value;
            enable_s_q <= bus.enable;
            dp_s_q     <= bus.dp;
        end
    end

    assign bus.SSEG_AN    = an_q;
    assign bus.SSEG_CA    = ca_q;
    assign bus.digit_idx  = digit_idx_q;
    assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver: 4 digits, 8-cycle slots, 2-cycle blank window.
// With SSEG_PWM_DIM_EN defined, a second instance exercises brightness gating.
module tb_sseg_scan_driver;
    localparam int ND = 4;
    localparam int DC = 8;
    localparam int BC = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    sseg_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    sseg_scan_driver #(.NUM_DIGITS(ND), .DIV_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

`ifdef SSEG_PWM_DIM_EN
    logic rst2_n = 1'b0;
    sseg_scan_driver_if #(.NUM_DIGITS(2)) bus2 ();

    sseg_scan_driver #(.NUM_DIGITS(2), .DIV_CYCLES(64), .BLANK_CYCLES(0)) dut2 (
        .clk     (clk),
        .reset_n (rst2_n),
        .bus     (bus2)
    );
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycles t0..t1 of the slot for digit d; output after each edge reflects timer=t.
    task automatic run_part(input int d, input logic [3:0] an, input logic [7:0] ca,
                            input int t0, input int t1);
        for (int t = t0; t <= t1; t++) begin
            step();
            check($sformatf("an d%0d t%0d", d, t), 32'(bus.SSEG_AN), (t < BC) ? 32'hF : 32'(an));
            check($sformatf("ca d%0d t%0d", d, t), 32'(bus.SSEG_CA), (t < BC) ? 32'hFF : 32'(ca));
            check($sformatf("idx d%0d t%0d", d, t), 32'(bus.digit_idx), 32'(d));
            check($sformatf("tick d%0d t%0d", d, t), 32'(bus.frame_tick),
                  (d == ND - 1 && t == DC - 1) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic run_slot(input int d, input logic [3:0] an, input logic [7:0] ca);
        run_part(d, an, ca, 0, DC - 1);
    endtask

    initial begin
        bus.value  = 16'h1234;
        bus.enable = 4'hF;
        bus.dp     = 4'h0;
`ifdef SSEG_PWM_DIM_EN
        bus.brightness  = 4'hF;
        bus2.value      = 8'h5A;
        bus2.enable     = 2'b11;
        bus2.dp         = 2'b00;
        bus2.brightness = 4'd3;
`endif
        repeat (3) step();
        check("rst an", 32'(bus.SSEG_AN), 32'hF);
        check("rst ca", 32'(bus.SSEG_CA), 32'hFF);
        check("rst idx", 32'(bus.digit_idx), 32'd0);
        check("rst tick", 32'(bus.frame_tick), 32'd0);
        reset_n = 1'b1;

        // Frame 1: digits 4,3,2,1
        run_slot(0, 4'b1110, 8'h99);
        run_slot(1, 4'b1101, 8'hB0);
        run_slot(2, 4'b1011, 8'hA4);
        run_slot(3, 4'b0111, 8'hF9);

        // Frame 2: value changes mid-slot1, frame keeps old digits
        run_slot(0, 4'b1110, 8'h99);
        run_part(1, 4'b1101, 8'hB0, 0, 3);
        bus.value = 16'hABCD;
        run_part(1, 4'b1101, 8'hB0, 4, DC - 1);
        run_slot(2, 4'b1011, 8'hA4);
        run_slot(3, 4'b0111, 8'hF9);

        // Frame 3: D,C,B,A; disable digit 2 for the next frame
        run_slot(0, 4'b1110, 8'hA1);
        bus.enable = 4'b1011;
        run_slot(1, 4'b1101, 8'hA7);
        run_slot(2, 4'b1011, 8'h83);
        run_slot(3, 4'b0111, 8'h88);

        // Frame 4: slot2 dark for all cycles
        run_slot(0, 4'b1110, 8'hA1);
        bus.value  = 16'h1234;
        bus.enable = 4'hF;
        bus.dp     = 4'b0010;
        run_slot(1, 4'b1101, 8'hA7);
        run_slot(2, 4'b1111, 8'hFF);
        run_slot(3, 4'b0111, 8'h88);

        // Frame 5: decimal point on digit 1
        run_slot(0, 4'b1110, 8'h99);
        run_slot(1, 4'b1101, 8'h30);
        run_slot(2, 4'b1011, 8'hA4);
        run_slot(3, 4'b0111, 8'hF9);

        // Frame 6: reset for one cycle with timer=4 in slot3
        run_slot(0, 4'b1110, 8'h99);
        run_slot(1, 4'b1101, 8'h30);
        run_slot(2, 4'b1011, 8'hA4);
        run_part(3, 4'b0111, 8'hF9, 0, 3);
        reset_n   = 1'b0;
        bus.value = 16'h5678;
        step();
        check("mid rst an", 32'(bus.SSEG_AN), 32'hF);
        check("mid rst ca", 32'(bus.SSEG_CA), 32'hFF);
        check("mid rst idx", 32'(bus.digit_idx), 32'd0);
        check("mid rst tick", 32'(bus.frame_tick), 32'd0);
        reset_n = 1'b1;

        // Scan restarts at slot0 with the value sampled during reset
        run_slot(0, 4'b1110, 8'h80);
        run_slot(1, 4'b1101, 8'h78);
        run_slot(2, 4'b1011, 8'h82);
        run_slot(3, 4'b0111, 8'h92);

`ifdef SSEG_PWM_DIM_EN
        rst2_n = 1'b1;
        // Slot0, brightness 3: 4 lit cycles per 16-cycle window
        for (int w = 0; w < 4; w++) begin
            int cnt = 0;
            for (int c = 0; c < 16; c++) begin
                step();
                if (bus2.SSEG_AN[0] == 1'b0) cnt++;
                check($sformatf("pwm ca d0 w%0d c%0d", w, c), 32'(bus2.SSEG_CA), 32'h88);
            end
            check($sformatf("pwm d0 w%0d", w), 32'(cnt), 32'd4);
        end
        bus2.brightness = 4'hF;
        // Slot1 still uses the snapshotted brightness 3
        for (int w = 0; w < 4; w++) begin
            int cnt = 0;
            for (int c = 0; c < 16; c++) begin
                step();
                if (bus2.SSEG_AN[1] == 1'b0) cnt++;
            end
            check($sformatf("pwm d1 w%0d", w), 32'(cnt), 32'd4);
        end
        begin
            int cnt = 0;
            for (int c = 0; c < 64; c++) begin
                step();
                if (bus2.SSEG_AN[0] == 1'b0) cnt++;
            end
            check("pwm full", 32'(cnt), 32'd64);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
